// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared machine-state encodings for the CPU control path
package cpu_pkg;

   // The decoder uses the same encodings to pick its per-state controls.
   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_EXEC1 = 2'b01,
      ST_EXEC2 = 2'b10,
      ST_HALT  = 2'b11
   } cpu_state_e;

endpackage

// File: rtl/retire_counter.sv
// rtl/retire_counter.sv - wrapping retired-instruction counter with enable
module retire_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;

   // Count up on each retire; the all-ones value rolls over to zero naturally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count_q <= '0;
      else if (en)
         count_q <= count_q + W'(1);
   end

   assign count = count_q;

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - FETCH/EXEC1/EXEC2/HALT sequencer; single-step under CPU_SINGLE_STEP_EN
module cpu_sequencer
   import cpu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sm_extra,
   input  logic             stop,
   input  logic             set_jump,
   input  logic             resume,
   input  logic             step_mode,
   input  logic             step_req,
   output logic [1:0]       state,
   output logic             jump,
   output logic             halted,
   output logic             paused,
   output logic             step_ack,
   output logic [CNT_W-1:0] retired
);

   cpu_state_e state_q, state_d;
   logic       halted_q, halted_d;
   logic       paused_q, paused_d;
   logic       step_ack_q, step_ack_d;
   logic       jump_q, jump_d;
   logic       retire_en;
   logic       step_on;
   logic       step_go;

`ifdef CPU_SINGLE_STEP_EN
   assign step_on = step_mode;
   assign step_go = step_req;
`else
   // Ports are kept for a uniform interface; the debug inputs have no effect.
   logic unused_step;
   assign unused_step = step_mode ^ step_req;
   assign step_on     = 1'b0;
   assign step_go     = 1'b0;
`endif

   // Next-state, halt/pause flags and retire strobe.
   always_comb begin
      state_d    = state_q;
      halted_d   = halted_q;
      paused_d   = paused_q;
      step_ack_d = 1'b0;
      retire_en  = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (stop) begin
               state_d  = ST_HALT;
               halted_d = 1'b1;
               paused_d = 1'b0;
            end else begin
               state_d = ST_EXEC1;
            end
         end
         ST_EXEC1: begin
            if (stop) begin
               state_d  = ST_HALT;
               halted_d = 1'b1;
               paused_d = 1'b0;
            end else if (sm_extra) begin
               state_d = ST_EXEC2;
            end else begin
               retire_en = 1'b1;
            end
         end
         ST_EXEC2: begin
            if (stop) begin
               state_d  = ST_HALT;
               halted_d = 1'b1;
               paused_d = 1'b0;
            end else begin
               retire_en = 1'b1;
            end
         end
         ST_HALT: begin
            // HALT only leaves on resume; PAUSE also leaves on a step or when stepping is switched off.
            if (halted_q) begin
               if (resume) begin
                  state_d  = ST_FETCH;
                  halted_d = 1'b0;
               end
            end else if (resume || step_go || !step_on) begin
               state_d  = ST_FETCH;
               paused_d = 1'b0;
            end
         end
         default: state_d = ST_FETCH;
      endcase
      // A retire goes to FETCH, or parks in PAUSE when stepping.
      if (retire_en) begin
         step_ack_d = step_on;
         if (step_on) begin
            state_d  = ST_HALT;
            paused_d = 1'b1;
         end else begin
            state_d = ST_FETCH;
         end
      end
   end

   // Jump flag: any set wins; otherwise the next instruction's EXEC1 clears it.
   // A stop out of EXEC1 leaves it alone since that instruction never completes.
   always_comb begin
      jump_d = jump_q;
      if ((state_q == ST_EXEC1 || state_q == ST_EXEC2) && set_jump)
         jump_d = 1'b1;
      else if (state_q == ST_EXEC1 && !stop)
         jump_d = 1'b0;
   end

   // State and flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_FETCH;
         halted_q   <= 1'b0;
         paused_q   <= 1'b0;
         step_ack_q <= 1'b0;
         jump_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         halted_q   <= halted_d;
         paused_q   <= paused_d;
         step_ack_q <= step_ack_d;
         jump_q     <= jump_d;
      end
   end

   retire_counter #(.W(CNT_W)) u_retire_counter (
      .clk   (clk),
      .reset (reset),
      .en    (retire_en),
      .count (retired)
   );

   assign state    = state_q;
   assign halted   = halted_q;
   assign paused   = paused_q;
   assign step_ack = step_ack_q;
   assign jump     = jump_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed vector bench for cpu_sequencer (either CPU_SINGLE_STEP_EN build)
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        sm_extra, stop, set_jump, resume, step_mode, step_req;
   logic [1:0]  state;
   logic        jump, halted, paused, step_ack;
   logic [15:0] retired;

   logic        reset_w;
   logic [1:0]  state_w;
   logic        jump_w, halted_w, paused_w, step_ack_w;
   logic [3:0]  retired_w;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cpu_sequencer #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .sm_extra(sm_extra), .stop(stop), .set_jump(set_jump),
      .resume(resume), .step_mode(step_mode), .step_req(step_req), .state(state),
      .jump(jump), .halted(halted), .paused(paused), .step_ack(step_ack), .retired(retired)
   );

   // Narrow counter instance so the rollover is reachable in a few dozen cycles.
   cpu_sequencer #(.CNT_W(4)) dut_w (
      .clk(clk), .reset(reset_w), .sm_extra(1'b0), .stop(1'b0), .set_jump(1'b0),
      .resume(1'b0), .step_mode(1'b0), .step_req(1'b0), .state(state_w),
      .jump(jump_w), .halted(halted_w), .paused(paused_w), .step_ack(step_ack_w),
      .retired(retired_w)
   );

   typedef struct {
      logic        sm_extra;
      logic        stop;
      logic        set_jump;
      logic        resume;
      logic [1:0]  e_state;
      logic        e_jump;
      logic        e_halted;
      logic [15:0] e_ret;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [1:0] e_state, input logic e_jump,
                          input logic e_halted, input logic e_paused, input logic e_ack,
                          input logic [15:0] e_ret);
      chk({tag, ".state"},    32'(state),    32'(e_state));
      chk({tag, ".jump"},     32'(jump),     32'(e_jump));
      chk({tag, ".halted"},   32'(halted),   32'(e_halted));
      chk({tag, ".paused"},   32'(paused),   32'(e_paused));
      chk({tag, ".step_ack"}, 32'(step_ack), 32'(e_ack));
      chk({tag, ".retired"},  32'(retired),  32'(e_ret));
   endtask

   initial begin
      // sm_extra, stop, set_jump, resume -> state, jump, halted, retired after the edge
      vecs.push_back('{0,0,0,0, 2'b01,0,0,16'd0});
      vecs.push_back('{0,0,0,0, 2'b00,0,0,16'd1});
      vecs.push_back('{0,0,0,0, 2'b01,0,0,16'd1});
      vecs.push_back('{0,0,0,0, 2'b00,0,0,16'd2});
      vecs.push_back('{0,0,0,0, 2'b01,0,0,16'd2});
      vecs.push_back('{0,0,0,0, 2'b00,0,0,16'd3});
      vecs.push_back('{0,0,0,0, 2'b01,0,0,16'd3});
      vecs.push_back('{1,0,0,0, 2'b10,0,0,16'd3});
      vecs.push_back('{0,0,0,0, 2'b00,0,0,16'd4});
      vecs.push_back('{0,0,0,0, 2'b01,0,0,16'd4});
      vecs.push_back('{0,0,0,0, 2'b00,0,0,16'd5});
      vecs.push_back('{0,0,0,0, 2'b01,0,0,16'd5});
      vecs.push_back('{0,1,0,0, 2'b11,0,1,16'd5});
      vecs.push_back('{0,0,0,0, 2'b11,0,1,16'd5});
      vecs.push_back('{0,0,0,1, 2'b00,0,0,16'd5});
      vecs.push_back('{0,0,0,0, 2'b01,0,0,16'd5});
      vecs.push_back('{0,0,1,0, 2'b00,1,0,16'd6});
      vecs.push_back('{0,0,0,0, 2'b01,1,0,16'd6});
      vecs.push_back('{0,0,0,0, 2'b00,0,0,16'd7});
      vecs.push_back('{0,0,0,1, 2'b01,0,0,16'd7});
      vecs.push_back('{1,0,1,0, 2'b10,1,0,16'd7});
      vecs.push_back('{0,0,0,0, 2'b00,1,0,16'd8});
      vecs.push_back('{0,0,0,0, 2'b01,1,0,16'd8});
      vecs.push_back('{1,0,0,0, 2'b10,0,0,16'd8});
      vecs.push_back('{0,0,1,0, 2'b00,1,0,16'd9});
      vecs.push_back('{0,0,0,0, 2'b01,1,0,16'd9});
      vecs.push_back('{0,0,0,0, 2'b00,0,0,16'd10});
      vecs.push_back('{0,1,0,0, 2'b11,0,1,16'd10});
      vecs.push_back('{0,0,0,1, 2'b00,0,0,16'd10});
      vecs.push_back('{0,0,0,0, 2'b01,0,0,16'd10});
      vecs.push_back('{1,1,0,0, 2'b11,0,1,16'd10});
      vecs.push_back('{0,0,0,1, 2'b00,0,0,16'd10});
      vecs.push_back('{0,0,0,0, 2'b01,0,0,16'd10});
      vecs.push_back('{1,0,0,0, 2'b10,0,0,16'd10});
      vecs.push_back('{0,1,0,0, 2'b11,0,1,16'd10});
      vecs.push_back('{0,0,0,1, 2'b00,0,0,16'd10});

      reset = 1'b1; reset_w = 1'b1;
      {sm_extra, stop, set_jump, resume, step_mode, step_req} = '0;
      cyc();
      cyc();
      chk_all("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

      // Counter rollover on the narrow instance: 16 retires of 2-cycle instructions.
      reset_w = 1'b0;
      for (int i = 0; i < 30; i++) cyc();
      chk("wrap.before", 32'(retired_w), 32'd15);
      chk("wrap.state",  32'(state_w),   32'd0);
      cyc();
      cyc();
      chk("wrap.after",  32'(retired_w), 32'd0);
      chk("wrap.state2", 32'(state_w),   32'd0);

      reset = 1'b0;
      for (int i = 0; i < vecs.size(); i++) begin
         sm_extra = vecs[i].sm_extra;
         stop     = vecs[i].stop;
         set_jump = vecs[i].set_jump;
         resume   = vecs[i].resume;
         cyc();
         chk_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_jump, vecs[i].e_halted,
                 1'b0, 1'b0, vecs[i].e_ret);
      end
      {sm_extra, stop, set_jump, resume} = '0;

`ifdef CPU_SINGLE_STEP_EN
      step_mode = 1'b1;
      cyc(); chk_all("step.exec1",  2'b01, 0, 0, 0, 0, 16'd10);
      cyc(); chk_all("step.pause",  2'b11, 0, 0, 1, 1, 16'd11);
      cyc(); chk_all("step.hold",   2'b11, 0, 0, 1, 0, 16'd11);
      cyc(); chk_all("step.hold2",  2'b11, 0, 0, 1, 0, 16'd11);
      step_req = 1'b1;
      cyc(); chk_all("step.go",     2'b00, 0, 0, 0, 0, 16'd11);
      step_req = 1'b0;
      cyc(); chk_all("step.exec1b", 2'b01, 0, 0, 0, 0, 16'd11);
      cyc(); chk_all("step.pause2", 2'b11, 0, 0, 1, 1, 16'd12);
      cyc(); chk_all("step.hold3",  2'b11, 0, 0, 1, 0, 16'd12);
      resume = 1'b1;
      cyc(); chk_all("step.resume", 2'b00, 0, 0, 0, 0, 16'd12);
      resume = 1'b0;
      cyc(); chk_all("step.exec1c", 2'b01, 0, 0, 0, 0, 16'd12);
      cyc(); chk_all("step.pause3", 2'b11, 0, 0, 1, 1, 16'd13);
      step_mode = 1'b0;
      cyc(); chk_all("step.off",    2'b00, 0, 0, 0, 0, 16'd13);
      step_mode = 1'b1;
      cyc(); chk_all("step.exec1d", 2'b01, 0, 0, 0, 0, 16'd13);
      stop = 1'b1;
      cyc(); chk_all("step.stop",   2'b11, 0, 1, 0, 0, 16'd13);
      stop = 1'b0; step_mode = 1'b0; resume = 1'b1;
      cyc(); chk_all("step.unhalt", 2'b00, 0, 0, 0, 0, 16'd13);
      resume = 1'b0;
`else
      step_mode = 1'b1;
      step_req  = 1'b1;
      cyc(); chk_all("nostep.exec1", 2'b01, 0, 0, 0, 0, 16'd10);
      cyc(); chk_all("nostep.ret",   2'b00, 0, 0, 0, 0, 16'd11);
      cyc(); chk_all("nostep.fetch", 2'b01, 0, 0, 0, 0, 16'd11);
      step_mode = 1'b0;
      step_req  = 1'b0;
      cyc(); chk_all("nostep.ret2",  2'b00, 0, 0, 0, 0, 16'd12);
`endif

      // Asynchronous reset in the middle of a 3-cycle instruction.
      sm_extra = 1'b1;
      set_jump = 1'b1;
      cyc(); chk("mid.fetch", 32'(state), 32'd1);
      cyc(); chk("mid.exec2", 32'(state), 32'd2);
      chk("mid.jump", 32'(jump), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk_all("mid.reset", 2'b00, 0, 0, 0, 0, 16'd0);
      {sm_extra, set_jump} = '0;
      cyc();
      reset = 1'b0;
      cyc(); chk_all("post.reset", 2'b01, 0, 0, 0, 0, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Control-path sequencer that generates the 2-bit machine state driven into the instruction decoder and consumes the decoder's sequencing requests (`sm_extra`, `stop`, `set_jump`). It steps each instruction through FETCH, EXEC1 and an optional EXEC2, and holds the core in HALT on a stop request. It owns the `jump` flag fed back to the decoder, counts retired instructions and provides an optional single-step debug mode. It sits beside the decoder and program counter in the CPU control path.

## Interface
- `CNT_W`, 16, width of the retired-instruction counter
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `sm_extra`  in  1  decoder request: current instruction needs EXEC2 (valid in EXEC1)
- `stop`  in  1  decoder halt request (stp in EXEC1, or stack overflow)
- `set_jump`  in  1  decoder: current cycle loads the PC (jump/call/return)
- `resume`  in  1  single-cycle pulse; leaves HALT
- `step_mode`  in  1  1 = pause after every retired instruction (SINGLE_STEP_EN only)
- `step_req`  in  1  pulse: release one instruction while paused (SINGLE_STEP_EN only)
- `state`  out  2  00 FETCH, 01 EXEC1, 10 EXEC2, 11 HALT/PAUSE
- `jump`  out  1  a PC load occurred in the previous instruction
- `halted`  out  1  in HALT due to `stop`
- `paused`  out  1  in PAUSE due to single-step
- `step_ack`  out  1  one-cycle pulse when a stepped instruction retires
- `retired`  out  CNT_W  count of retired instructions

## Operation
- Reset: `state`=00, `jump`=0, `halted`=0, `paused`=0, `step_ack`=0, `retired`=0.
- FETCH -> EXEC1 unconditionally (unless `stop`).
- EXEC1 -> EXEC2 if `sm_extra`=1, else retire -> FETCH.
- EXEC2 -> retire -> FETCH.
- `stop`=1 in any of FETCH/EXEC1/EXEC2 wins over all other transitions: next state HALT, `halted`=1, instruction not retired, `retired` unchanged.
- HALT: `state`=11; `resume` pulse -> FETCH, `halted` cleared same edge. `resume` outside HALT/PAUSE ignored.
- Retire: `retired` += 1, wraps from 2^CNT_W−1 to 0.
- `jump`: set at any edge where `set_jump`=1 in EXEC1/EXEC2; cleared at the edge leaving EXEC1 of the next instruction, unless `set_jump`=1 in that same cycle (set wins). Unaffected by HALT.
- Single-step (macro defined): when `step_mode`=1, a retire goes to PAUSE (`state`=11, `paused`=1) instead of FETCH. `step_req` in PAUSE -> FETCH, `paused` cleared. `step_ack` pulses for the cycle after each retire that occurs while `step_mode`=1. `step_mode` dropped while paused -> FETCH next edge. `resume` also exits PAUSE. `stop` takes priority over pause: the core enters HALT with `halted`=1, `paused`=0.

## Timing
- One state per clock; 2-cycle instructions take FETCH+EXEC1, 3-cycle instructions take FETCH+EXEC1+EXEC2.
- All outputs registered; `state` changes one edge after the sampled request.
- `retired` updates on the edge leaving the final exec state.
- Reset asserted mid-instruction: immediate return to reset values; no partial retire.
- Earliest exit from HALT or PAUSE: FETCH on the edge after `resume` or `step_req`.

## Configuration
- `CPU_SINGLE_STEP_EN`: when defined, PAUSE, `step_mode`, `step_req` and `step_ack` are implemented as above. When undefined, the ports remain, inputs are ignored, `paused`=0 and `step_ack`=0 constantly, and retire always goes to FETCH.

## Structure
- Shared package `cpu_pkg`: state encodings `ST_FETCH`=2'b00, `ST_EXEC1`=2'b01, `ST_EXEC2`=2'b10, `ST_HALT`=2'b11. Same encodings are used by the decoder.
- One sub-module: `retire_counter` (CNT_W wrapping counter with enable and async reset).

## Test plan
- Reset, then `sm_extra`=0 for three instructions -> `state` 00,01,00,01,00,01; `retired`=3.
- `sm_extra`=1 in EXEC1 -> `state` 01 then 10 then 00; `retired` increments once, on the edge leaving 10.
- `set_jump`=1 in EXEC1 of instruction A -> `jump`=1 through EXEC1 of instruction B, 0 from the following FETCH.
- `stop`=1 in EXEC1 with `retired`=5 -> `state`=11, `halted`=1, `retired`=5; `resume` pulse -> `state`=00, `halted`=0.
- Preload `retired`=16'hFFFF and retire one instruction -> `retired`=16'h0000.
- Macro defined, `step_mode`=1 -> after one instruction `state`=11, `paused`=1, `step_ack` pulses once; `step_req` -> exactly one more instruction runs and the core pauses again.
